lsu_m: RTL and testbench

Memory-stage load/store unit of the pipelined RISC-V core. It sits directly downstream of the EX/MEM pipeline register and consumes its M-stage control (store enable, load select) together with the registered ALU address and store data. It serves an internal data memory and a memory-mapped I/O window. Loads use a one-cycle synchronous read, and the block stalls the pipeline while a load is in flight.

---
 rtl/lsu_m.sv | 171 +++++++++++++++++
 tb/tb_lsu_m.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_m.sv
// Memory-stage load/store unit: byte-lane DMEM with one-cycle registered reads, load stall FSM.
// Define LSU_IO_EN to include the LEDR/LEDG/SW memory-mapped I/O window.
module lsu_m #(
  parameter int DMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg
);
  localparam int AW = $clog2(DMEM_WORDS);

  typedef enum logic {S_IDLE, S_LOAD_WAIT} state_e;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        dmem_q;
  logic [31:0] io_rdata_q;
  logic [31:0] ld_data_q;
  logic        ld_valid_q;
  logic        misaligned_q;

  logic        is_byte, is_half, is_word, misal;
  logic        idle, st_go, ld_go, mis_any, mis_ld, dmem_we;
  logic        hit_dmem;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] io_rdata, mem_rdata, ld_raw, ld_shift, ld_result;

  // funct3[1:0] selects size; any encoding other than B/H is treated as a word
  assign is_byte = (i_funct3[1:0] == 2'b00);
  assign is_half = (i_funct3[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;
  assign misal   = (is_half && i_lsu_addr[0]) || (is_word && (i_lsu_addr[1:0] != 2'b00));

  assign idle    = (state_q == S_IDLE);
  assign st_go   = idle && i_lsu_wren && !misal;
  assign ld_go   = idle && i_lsu_rden && !i_lsu_wren && !misal;
  assign mis_any = idle && (i_lsu_wren || i_lsu_rden) && misal;
  assign mis_ld  = idle && i_lsu_rden && !i_lsu_wren && misal;

  assign hit_dmem = (i_lsu_addr[31:AW+2] == '0);
  assign idx      = i_lsu_addr[AW+1:2];
  assign dmem_we  = st_go && hit_dmem && !i_rst;

  always_comb begin
    be    = 4'b1111;
    wdata = i_st_data;
    if (is_byte) begin
      be    = 4'b0001 << i_lsu_addr[1:0];
      wdata = {4{i_st_data[7:0]}};
    end else if (is_half) begin
      be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{i_st_data[15:0]}};
    end
  end

  // One byte-wide array per lane keeps each lane a plain single-port RAM
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DMEM_WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge i_clk) begin
      if (dmem_we && be[gi]) lane_mem[idx] <= wdata[8*gi +: 8];
      if (ld_go) rd_q <= lane_mem[idx];
    end
    assign mem_rdata[8*gi +: 8] = rd_q;
  end

`ifdef LSU_IO_EN
  logic [31:0] ledr_q, ledg_q, sw_meta_q, sw_sync_q;
  logic        hit_ledr, hit_ledg, hit_sw;

  assign hit_ledr = (i_lsu_addr[31:2] == 30'h0400_0000);
  assign hit_ledg = (i_lsu_addr[31:2] == 30'h0400_0400);
  assign hit_sw   = (i_lsu_addr[31:2] == 30'h0400_4000);
  assign io_rdata = hit_ledr ? ledr_q :
                    hit_ledg ? ledg_q :
                    hit_sw   ? sw_sync_q : 32'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q    <= '0;
      ledg_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
      for (int b = 0; b < 4; b++) begin
        if (st_go && hit_ledr && be[b]) ledr_q[8*b +: 8] <= wdata[8*b +: 8];
        if (st_go && hit_ledg && be[b]) ledg_q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
`else
  logic unused_io_sw;
  assign unused_io_sw = ^i_io_sw;
  assign io_rdata     = 32'd0;
  assign o_io_ledr    = 32'd0;
  assign o_io_ledg    = 32'd0;
`endif

  // Aligned accesses only reach here, so a word load always has a zero lane offset
  assign ld_raw   = dmem_q ? mem_rdata : io_rdata_q;
  assign ld_shift = ld_raw >> {off_q, 3'b000};

  always_comb begin
    unique case (funct3_q)
      3'b000:  ld_result = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_result = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_result = {24'd0, ld_shift[7:0]};
      3'b101:  ld_result = {16'd0, ld_shift[15:0]};
      default: ld_result = ld_shift;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      funct3_q     <= '0;
      dmem_q       <= 1'b0;
      io_rdata_q   <= '0;
      ld_data_q    <= '0;
      ld_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      ld_valid_q   <= ld_go || mis_ld;
      misaligned_q <= mis_any;
      unique case (state_q)
        S_IDLE: begin
          if (ld_go) begin
            state_q    <= S_LOAD_WAIT;
            off_q      <= i_lsu_addr[1:0];
            funct3_q   <= i_funct3;
            dmem_q     <= hit_dmem;
            io_rdata_q <= io_rdata;
          end
          if (mis_ld) ld_data_q <= '0;
        end
        S_LOAD_WAIT: begin
          state_q   <= S_IDLE;
          ld_data_q <= ld_result;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result is live in the wait cycle, then held until the next load
  assign o_ld_data    = (state_q == S_LOAD_WAIT) ? ld_result : ld_data_q;
  assign o_ld_valid   = ld_valid_q;
  assign o_stall      = ld_go;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu_m.sv
// Scoreboard bench for lsu_m: byte-array reference model, queued load expectations, random traffic.
module tb_lsu_m;
  localparam int DW = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_addr, st_data, io_sw;
  logic        lsu_wren, lsu_rden;
  logic [2:0]  funct3;
  logic [31:0] ld_data, io_ledr, io_ledg;
  logic        ld_valid, stall, misaligned;

  lsu_m #(.DMEM_WORDS(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_lsu_addr(lsu_addr), .i_st_data(st_data),
    .i_lsu_wren(lsu_wren), .i_lsu_rden(lsu_rden), .i_funct3(funct3), .i_io_sw(io_sw),
    .o_ld_data(ld_data), .o_ld_valid(ld_valid), .o_stall(stall),
    .o_misaligned(misaligned), .o_io_ledr(io_ledr), .o_io_ledg(io_ledg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  dm [0:4*DW-1];
  logic [31:0] ledr_m = 0, ledg_m = 0, sw_m = 0, last_ld = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
    end
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % 32'(size_of(f3))) != 0;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] addr);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    if (wa < 4*DW) return {dm[wa+3], dm[wa+2], dm[wa+1], dm[wa]};
`ifdef LSU_IO_EN
    if (wa == 32'h1000_0000) return ledr_m;
    if (wa == 32'h1000_1000) return ledg_m;
    if (wa == 32'h1001_0000) return sw_m;
`endif
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] w;
    w = read_word(addr) >> (8 * addr[1:0]);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a;
    logic [7:0]  b;
    for (int i = 0; i < size_of(f3); i++) begin
      a = addr + 32'(i);
      b = data[8*i +: 8];
      if (a < 4*DW) dm[a] = b;
`ifdef LSU_IO_EN
      else if (a[31:2] == 30'h0400_0000) ledr_m[8*a[1:0] +: 8] = b;
      else if (a[31:2] == 30'h0400_0400) ledg_m[8*a[1:0] +: 8] = b;
`endif
    end
  endfunction

  // Monitor: every presented load result is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && ld_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_ld_valid: got data %08h with no load outstanding", ld_data);
      end else begin
        chk("ld_data", ld_data, exp_q.pop_front());
      end
    end
  end

  task automatic set_idle();
    lsu_wren = 1'b0; lsu_rden = 1'b0; funct3 = 3'b010; lsu_addr = 32'd0; st_data = 32'd0;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at #1 after a rising edge; returns at #1 after a rising edge
  task automatic do_op(input bit we, input bit re, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input bit has_exp, input logic [31:0] exp_v);
    bit ldreq, mis;
    logic [31:0] e;
    ldreq = re && !we;
    mis   = (we || re) && is_mis(f3, addr);
    lsu_wren = we; lsu_rden = re; funct3 = f3; lsu_addr = addr; st_data = data;
    $display("txn we=%0d re=%0d f3=%0d addr=%08h data=%08h mis=%0d", we, re, f3, addr, data, mis);
    if (we && !mis) model_store(f3, addr, data);
    if (ldreq) begin
      e = mis ? 32'd0 : (has_exp ? exp_v : model_load(f3, addr));
      exp_q.push_back(e);
      last_ld = e;
    end
    @(negedge clk);
    chk("stall_req", 32'(stall), 32'(ldreq && !mis));
    @(posedge clk); #1;
    set_idle();
    chk("misaligned", 32'(misaligned), 32'(mis));
    chk("ld_valid", 32'(ld_valid), 32'(ldreq));
    chk("ledr", io_ledr, ledr_m);
    chk("ledg", io_ledg, ledg_m);
    if (ldreq || mis) begin
      @(negedge clk);
      chk("stall_wait", 32'(stall), 32'd0);
      @(posedge clk); #1;
      if (ldreq) chk("ld_hold", ld_data, last_ld);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] off;
    off = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 11))
      7:  return 4*DW - 4 + off;
      8:  return 32'h1000_0000 + off;
      9:  return 32'h1000_1000 + off;
      10: return 32'h1001_0000 + off;
      11: return ($urandom_range(0, 1) == 0) ? 4*DW + off : 32'h1000_0004 + off;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit we, re;
    logic [2:0] f3;
    rst = 1'b1; io_sw = 32'd0;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_ledr", io_ledr, 32'd0);
    chk("rst_ledg", io_ledg, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int w = 0; w < 64; w++) do_op(1, 0, 3'b010, 32'(4*w), $urandom, 0, 0);
    do_op(1, 0, 3'b010, 32'h1000, $urandom, 0, 0);
    do_op(1, 0, 3'b010, 4*DW - 4, $urandom, 0, 0);

    do_op(1, 0, 3'b010, 32'h10, 32'h8765_4321, 0, 0);
    do_op(0, 1, 3'b010, 32'h10, 0, 1, 32'h8765_4321);
    do_op(1, 0, 3'b000, 32'h13, 32'h0000_00AA, 0, 0);
    do_op(0, 1, 3'b000, 32'h13, 0, 1, 32'hFFFF_FFAA);
    do_op(0, 1, 3'b100, 32'h13, 0, 1, 32'h0000_00AA);
    do_op(0, 1, 3'b010, 32'h10, 0, 1, 32'hAA65_4321);
    do_op(1, 0, 3'b001, 32'h22, 32'h0000_8001, 0, 0);
    do_op(0, 1, 3'b001, 32'h22, 0, 1, 32'hFFFF_8001);
    do_op(0, 1, 3'b101, 32'h22, 0, 1, 32'h0000_8001);
    do_op(0, 1, 3'b010, 32'h1002, 0, 0, 0);
    do_op(1, 0, 3'b001, 32'h1003, 32'h0000_1234, 0, 0);
    do_op(0, 1, 3'b010, 32'h1000, 0, 0, 0);
    do_op(1, 1, 3'b010, 32'h14, 32'h1357_9BDF, 0, 0);
    do_op(0, 1, 3'b010, 32'h14, 0, 1, 32'h1357_9BDF);

    do_op(1, 0, 3'b010, 32'h1000_0000, 32'h0000_00FF, 0, 0);
`ifdef LSU_IO_EN
    chk("ledr_plan", io_ledr, 32'h0000_00FF);
`else
    chk("ledr_plan", io_ledr, 32'd0);
`endif
    io_sw = 32'h5A; sw_m = 32'h5A;
    idle_cycles(3);
`ifdef LSU_IO_EN
    do_op(0, 1, 3'b010, 32'h1001_0000, 0, 1, 32'h5A);
`else
    do_op(0, 1, 3'b010, 32'h1001_0000, 0, 1, 32'd0);
`endif

    // Reset during the wait cycle discards the pending result but keeps DMEM
    lsu_rden = 1'b1; funct3 = 3'b010; lsu_addr = 32'h10;
    exp_q.push_back(model_load(3'b010, 32'h10));
    @(negedge clk);
    chk("stall_pre_rst", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    ledr_m = 0; ledg_m = 0; last_ld = 0;
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_ld_valid", 32'(ld_valid), 32'd0);
    chk("rstw_ld_data", ld_data, 32'd0);
    chk("rstw_ledr", io_ledr, 32'd0);
    idle_cycles(3);
    do_op(0, 1, 3'b010, 32'h10, 0, 1, 32'hAA65_4321);

    for (int n = 0; n < 300; n++) begin
      we = ($urandom_range(0, 2) == 0);
      re = we ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_op(we, re, f3, pick_addr(), $urandom, 0, 0);
    end

    idle_cycles(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
